// File: rtl/spread_ctrl.sv
// spread_ctrl: maps 4-bit symbols onto 32-chip PN sequences, one chip per
// i_EN strobe, with a one-entry hold register so symbols chain gap-free.
//
// Ports:
//   i_CLK        system clock, rising edge
//   i_RST        asynchronous active-high reset
//   i_EN         chip-rate strobe (one chip per high cycle while shifting)
//   i_FLUSH      synchronous abort of active and held symbols
//   i_SYM        symbol to spread
//   i_SYM_VALID  i_SYM is valid
//   o_SYM_READY  hold register empty, a symbol can be taken
//   o_CHIP       registered serial chip (IDLE_CHIP when not valid)
//   o_CHIP_VALID o_CHIP valid this cycle
//   o_SYM_DONE   one-cycle pulse with the last chip of a symbol
//   o_BUSY       a symbol is active or held
module spread_ctrl #(
   parameter logic [31:0] CHIP_SEQ0 = 32'h744A_C39B,
   parameter logic        IDLE_CHIP = 1'b0
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_EN,
   input  logic       i_FLUSH,
   input  logic [3:0] i_SYM,
   input  logic       i_SYM_VALID,
   output logic       o_SYM_READY,
   output logic       o_CHIP,
   output logic       o_CHIP_VALID,
   output logic       o_SYM_DONE,
   output logic       o_BUSY
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [3:0] a_q, a_d;
   logic [3:0] hold_q, hold_d;
   logic       hv_q, hv_d;
   logic       chip_q, chip_d;
   logic       vld_q, vld_d;
   logic       done_q, done_d;
   logic [4:0] idx;
   logic       accept;

   // Each symbol step rotates the base sequence right by 4 chips.
   assign idx    = cnt_q - {a_q[2:0], 2'b00};
   assign accept = i_SYM_VALID && !hv_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      hold_d  = hold_q;
      hv_d    = hv_q;
      chip_d  = IDLE_CHIP;
      vld_d   = 1'b0;
      done_d  = 1'b0;
      if (i_FLUSH) begin
         hv_d    = 1'b0;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         // accept only when hv_q=0, so it never collides with a
         // transfer out of the hold register below
         if (accept) begin
            hv_d   = 1'b1;
            hold_d = i_SYM;
         end
         unique case (state_q)
            IDLE: begin
               if (hv_q) begin
                  a_d     = hold_q;
                  hv_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (i_EN) begin
                  // upper half of the alphabet inverts odd chips
                  chip_d = CHIP_SEQ0[idx] ^ (a_q[3] & cnt_q[0]);
                  vld_d  = 1'b1;
                  cnt_d  = cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     done_d = 1'b1;
                     if (hv_q) begin
                        a_d  = hold_q;
                        hv_d = 1'b0;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         hold_q  <= '0;
         hv_q    <= 1'b0;
         chip_q  <= IDLE_CHIP;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         hold_q  <= hold_d;
         hv_q    <= hv_d;
         chip_q  <= chip_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   assign o_SYM_READY  = !hv_q;
   assign o_CHIP       = chip_q;
   assign o_CHIP_VALID = vld_q;
   assign o_SYM_DONE   = done_q;
   assign o_BUSY       = (state_q == SHIFT) || hv_q;

endmodule

// File: tb/tb_spread_ctrl.sv
// tb_spread_ctrl: directed and random stimulus for spread_ctrl, checked
// cycle by cycle against a symbol/chip-level reference model.
module tb_spread_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] sym = 4'd0;
   logic       sym_v = 1'b0;
   logic       o_sym_ready, o_chip, o_chip_valid, o_sym_done, o_busy;

   int checks = 0;
   int errors = 0;

   // c0 is the leftmost digit, so chip j lives at bit 31-j
   logic [31:0] seq_str = 32'b11011001110000110101001000101110;

   // reference model state
   bit       m_hold_v, m_act, m_vld, m_chip, m_done;
   bit [3:0] m_hold_s, m_act_s;
   int       m_pos;

   spread_ctrl dut (
      .i_CLK(clk),
      .i_RST(rst),
      .i_EN(en),
      .i_FLUSH(flush),
      .i_SYM(sym),
      .i_SYM_VALID(sym_v),
      .o_SYM_READY(o_sym_ready),
      .o_CHIP(o_chip),
      .o_CHIP_VALID(o_chip_valid),
      .o_SYM_DONE(o_sym_done),
      .o_BUSY(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit ref_chip(input int s, input int j);
      int k;
      bit c;
      k = (((j - 4 * (s % 8)) % 32) + 32) % 32;
      c = seq_str[31 - k];
      if (s >= 8 && (j % 2) == 1) c = !c;
      return c;
   endfunction

   function automatic void model_reset();
      m_hold_v = 0; m_act = 0; m_vld = 0; m_chip = 0; m_done = 0;
      m_hold_s = 0; m_act_s = 0; m_pos = 0;
   endfunction

   function automatic void model_step();
      bit take;
      take = sym_v && !m_hold_v;
      m_vld = 0; m_chip = 0; m_done = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (flush) begin
         m_hold_v = 0; m_act = 0; m_pos = 0;
         return;
      end
      if (m_act && en) begin
         m_vld  = 1;
         m_chip = ref_chip(m_act_s, m_pos);
         if (m_pos == 31) begin
            m_done = 1;
            m_pos  = 0;
            if (m_hold_v) begin
               m_act_s  = m_hold_s;
               m_hold_v = 0;
            end else begin
               m_act = 0;
            end
         end else begin
            m_pos++;
         end
      end else if (!m_act && m_hold_v) begin
         m_act = 1; m_act_s = m_hold_s; m_hold_v = 0; m_pos = 0;
      end
      if (take) begin
         m_hold_v = 1;
         m_hold_s = sym;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("vld", o_chip_valid, m_vld);
      chk("chip", o_chip, m_chip);
      chk("done", o_sym_done, m_done);
      chk("busy", o_busy, m_act || m_hold_v);
      chk("rdy", o_sym_ready, !m_hold_v);
   endtask

   task automatic send(input logic [3:0] s);
      int n;
      n = 0;
      while (m_hold_v && n < 64) begin
         tick();
         n++;
      end
      sym = s; sym_v = 1'b1;
      tick();
      sym_v = 1'b0; sym = 4'($urandom);
   endtask

   task automatic collect(input int budget, input int want, input int en_div,
                          output logic [63:0] vec, output int nch,
                          output int ndone, output int span);
      int first;
      first = -1; vec = '0; nch = 0; ndone = 0; span = 0;
      for (int k = 0; k < budget && nch < want; k++) begin
         en = ((k % en_div) == 0);
         tick();
         if (o_chip_valid) begin
            vec = {vec[62:0], o_chip};
            if (first < 0) first = k;
            span = k - first;
            nch++;
         end
         if (o_sym_done) ndone++;
      end
   endtask

   logic [63:0] vec, ev;
   int nch, ndone, span, nv;

   initial begin
      model_reset();
      #2;
      chk("rst_vld", o_chip_valid, 0);
      chk("rst_chip", o_chip, 0);
      chk("rst_done", o_sym_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_rdy", o_sym_ready, 1);
      tick(); tick();
      rst = 1'b0;
      tick();

      // symbol 0, continuous strobe
      en = 1'b1;
      send(4'd0);
      collect(45, 999, 1, vec, nch, ndone, span);
      chk("s0_n", nch, 32);
      chk("s0_seq", vec[31:0], 32'b11011001110000110101001000101110);
      chk("s0_done", ndone, 1);
      chk("s0_idle", o_busy, 0);

      send(4'd1);
      collect(45, 999, 1, vec, nch, ndone, span);
      chk("s1_seq", vec[31:0], 32'b11101101100111000011010100100010);
      chk("s1_done", ndone, 1);

      send(4'd8);
      collect(45, 999, 1, vec, nch, ndone, span);
      chk("s8_seq", vec[31:0], 32'b10001100100101100000011101111011);
      chk("s8_done", ndone, 1);

      // 3 then 5 back to back, strobe every 4th cycle
      en = 1'b0;
      send(4'd3);
      send(4'd5);
      collect(400, 64, 4, vec, nch, ndone, span);
      ev = '0;
      for (int j = 0; j < 32; j++) ev = {ev[62:0], ref_chip(3, j)};
      for (int j = 0; j < 32; j++) ev = {ev[62:0], ref_chip(5, j)};
      chk("b2b_n", nch, 64);
      chk("b2b_seq", vec, ev);
      chk("b2b_done", ndone, 2);
      chk("b2b_span", span, 63 * 4);
      collect(10, 999, 1, vec, nch, ndone, span);
      chk("b2b_tail", nch, 0);

      // flush after chip 10 with a held symbol
      en = 1'b1;
      send(4'd2);
      send(4'd9);
      collect(60, 10, 1, vec, nch, ndone, span);
      chk("fl_pre", nch, 10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_busy", o_busy, 0);
      chk("fl_rdy", o_sym_ready, 1);
      collect(40, 999, 1, vec, nch, ndone, span);
      chk("fl_nchip", nch, 0);
      chk("fl_ndone", ndone, 0);

      // async reset between edges in mid-symbol
      send(4'd6);
      repeat (12) tick();
      #3;
      rst = 1'b1;
      #1;
      chk("ar_vld", o_chip_valid, 0);
      chk("ar_chip", o_chip, 0);
      chk("ar_done", o_sym_done, 0);
      chk("ar_busy", o_busy, 0);
      chk("ar_rdy", o_sym_ready, 1);
      model_reset();
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      send(4'd11);
      collect(45, 999, 1, vec, nch, ndone, span);
      ev = '0;
      for (int j = 0; j < 32; j++) ev = {ev[62:0], ref_chip(11, j)};
      chk("ar_n", nch, 32);
      chk("ar_seq", vec[31:0], ev[31:0]);
      chk("ar_sdone", ndone, 1);

      // random strobe while idle
      nv = 0;
      for (int k = 0; k < 40; k++) begin
         en = 1'($urandom);
         tick();
         if (o_chip_valid || o_chip) nv++;
      end
      chk("idle_en", nv, 0);

      // fully random traffic
      for (int k = 0; k < 1500; k++) begin
         en    = 1'($urandom);
         sym_v = ($urandom % 3) == 0;
         sym   = 4'($urandom);
         flush = ($urandom % 120) == 0;
         tick();
      end
      flush = 1'b0; sym_v = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spread_ctrl.md
SPREAD_CTRL -- requirements
Module: spread_ctrl

Interface
REQ-001 SHALL have parameter CHIP_SEQ0, default 32 bits with bit j = chip c_j, c0..c31 = 11011001110000110101001000101110, giving the symbol-0 PN chip sequence.
REQ-002 SHALL have parameter IDLE_CHIP, default 1'b0, giving the o_CHIP value driven whenever no chip is valid.
REQ-003 SHALL have port i_CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port i_RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_EN  input  1  chip-rate strobe; one chip is emitted per cycle in which it is high.
REQ-006 SHALL have port i_FLUSH  input  1  synchronous abort of the active and held symbols.
REQ-007 SHALL have port i_SYM  input  4  symbol to spread.
REQ-008 SHALL have port i_SYM_VALID  input  1  i_SYM is valid.
REQ-009 SHALL have port o_SYM_READY  output  1  the block can accept a symbol this cycle.
REQ-010 SHALL have port o_CHIP  output  1  serial chip, registered.
REQ-011 SHALL have port o_CHIP_VALID  output  1  o_CHIP is valid this cycle.
REQ-012 SHALL have port o_SYM_DONE  output  1  one-cycle pulse after chip 31 of a symbol.
REQ-013 SHALL have port o_BUSY  output  1  a symbol is active or held.

Function
REQ-014 SHALL hold symbols in a 1-entry register (flag hv plus 4-bit value); o_SYM_READY SHALL equal !hv and be driven from registers only.
REQ-015 SHALL accept a symbol (set hv, store i_SYM) when i_SYM_VALID && o_SYM_READY; i_SYM SHALL be ignored otherwise.
REQ-016 SHALL implement an FSM with two states: IDLE and SHIFT.
REQ-017 In IDLE with hv=1, the block SHALL copy the hold register into the active register A, clear hv, set the 5-bit counter cnt to 0, and enter SHIFT; no chip is emitted in that cycle.
REQ-018 In IDLE, i_EN SHALL be ignored.
REQ-019 In SHIFT with i_EN=1, next cycle the block SHALL drive o_CHIP = chip(A,cnt) and o_CHIP_VALID=1, and SHALL increment cnt (wrapping 31 -> 0).
REQ-020 In every cycle not covered by REQ-019, next cycle o_CHIP_VALID SHALL be 0 and o_CHIP SHALL be IDLE_CHIP.
REQ-021 chip(s,j) SHALL equal CHIP_SEQ0[(j - 4*s[2:0]) mod 32], inverted when s[3]=1 and j is odd (right cyclic shift by 4 chips per symbol step; symbols 8-15 invert odd chips).
REQ-022 In SHIFT with i_EN=1 and cnt=31, next cycle o_SYM_DONE SHALL pulse high for one cycle.
REQ-023 In the same cycle as REQ-022, if hv=1 the block SHALL load A from the hold register, clear hv, and stay in SHIFT, so the next i_EN emits chip 0 of the new symbol with no lost strobe; if hv=0 it SHALL return to IDLE.
REQ-024 A symbol accepted in the same cycle as the REQ-023 transfer is impossible, since o_SYM_READY=0 while hv=1; the hold register refills from the following cycle.
REQ-025 o_BUSY SHALL be registered-equivalent to (state==SHIFT) || hv.
REQ-026 i_FLUSH=1 SHALL, next cycle, clear hv, set state to IDLE and cnt to 0, and force o_CHIP_VALID=0 and o_SYM_DONE=0; i_FLUSH SHALL take priority over i_EN and over symbol acceptance in the same cycle.

Reset
REQ-027 While i_RST=1, the block SHALL immediately and asynchronously force state=IDLE, cnt=0, hv=0, A=0, o_CHIP=IDLE_CHIP, o_CHIP_VALID=0, o_SYM_DONE=0, o_BUSY=0, o_SYM_READY=1.
REQ-028 Reset asserted mid-symbol SHALL discard the active and held symbols; no chip or o_SYM_DONE SHALL appear after reset until a new symbol is accepted.

Verification
REQ-029 Bench SHALL cover: symbol 0 with i_EN high continuously -> 32 valid chips 11011001110000110101001000101110, then one o_SYM_DONE pulse, then IDLE.
REQ-030 Bench SHALL cover: symbol 1 -> chips 11101101100111000011010100100010; symbol 8 -> 10001100100101100000011101111011.
REQ-031 Bench SHALL cover: symbols 3 then 5 offered back to back with i_EN every 4th cycle -> 64 contiguous chips with no missing strobe, o_SYM_READY low only while hv=1, and two o_SYM_DONE pulses.
REQ-032 Bench SHALL cover: i_FLUSH after chip 10 with a held symbol -> no further o_CHIP_VALID, o_BUSY=0 next cycle, o_SYM_READY=1.
REQ-033 Bench SHALL cover: i_RST asserted asynchronously mid-symbol (between clock edges) -> outputs reach reset values before the next edge; a new symbol afterwards starts at chip 0.
REQ-034 Bench SHALL cover: i_EN toggling randomly while IDLE with no symbol -> o_CHIP_VALID stays 0 and o_CHIP=IDLE_CHIP.
